// File: rtl/dn_port_arbiter.sv
// dn_port_arbiter: round-robin sharing of the TRS-80 download port.
// Optional DN_ARB_TIMEOUT_EN: drop a write whose dn_ack never arrives.
module dn_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ld_active,
  input  logic        ld_wr,
  input  logic [15:0] ld_addr,
  input  logic [7:0]  ld_data,
  output logic        ld_wait,
  input  logic        io_active,
  input  logic        io_wr,
  input  logic [15:0] io_addr,
  input  logic [7:0]  io_data,
  output logic        io_wait,
  input  logic        exec_req,
  input  logic [15:0] exec_addr,
  output logic        dn_go,
  output logic        dn_wr,
  output logic [23:0] dn_addr,
  output logic [7:0]  dn_data,
  input  logic        dn_ack,
  output logic        exec_go,
  output logic [15:0] exec_pc,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  typedef struct packed {
    logic        vld;
    logic [15:0] addr;
    logic [7:0]  data;
  } hold_t;

  state_t      state_q, state_d;
  hold_t       ld_q, ld_d;
  hold_t       io_q, io_d;
  logic        gnt_q, gnt_d;
  logic        last_q, last_d;
  logic [23:0] dn_addr_q, dn_addr_d;
  logic [7:0]  dn_data_q, dn_data_d;
  logic        dn_go_q, dn_go_d;
  logic        pend_q, pend_d;
  logic [15:0] xaddr_q, xaddr_d;
  logic [15:0] pc_q, pc_d;
  logic        xgo_q, xgo_d;
  logic        err_q, err_d;

  logic        any_vld;
  logic        done;
  logic        tmo;
  logic        fire;

  assign any_vld = ld_q.vld | io_q.vld;

`ifdef DN_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;

  // Count cycles spent waiting for the core to commit the write.
  always_comb begin
    cnt_d = '0;
    if (state_q == S_WAIT && !dn_ack) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  assign tmo = (state_q == S_WAIT) && !dn_ack &&
               (cnt_q == 16'(TIMEOUT_CYCLES - 1));

  // Timeout counter register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES != 0);
  assign tmo = 1'b0;
`endif

  // The granted write retires on ack, or is abandoned on timeout.
  assign done = (state_q == S_WAIT) && (dn_ack || tmo);

  // Next-state logic of the grant FSM.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (any_vld) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Pick a source in IDLE and latch its entry onto the port.
  always_comb begin
    gnt_d     = gnt_q;
    dn_addr_d = dn_addr_q;
    dn_data_d = dn_data_q;
    if (state_q == S_IDLE) begin
      unique case (1'b1)
        ld_q.vld && !io_q.vld: gnt_d = 1'b0;
        !ld_q.vld && io_q.vld: gnt_d = 1'b1;
        ld_q.vld && io_q.vld:  gnt_d = ~last_q;
        default:               gnt_d = gnt_q;
      endcase
      if (any_vld) begin
        if (gnt_d) begin
          dn_addr_d = {8'h01, io_q.addr};
          dn_data_d = io_q.data;
        end else begin
          dn_addr_d = {8'h00, ld_q.addr};
          dn_data_d = ld_q.data;
        end
      end
    end
  end

  // Remember who was served last so ties alternate.
  always_comb begin
    last_d = last_q;
    if (done) begin
      last_d = gnt_q;
    end
  end

  // Holding registers; a strobe into a full entry is lost and flagged.
  always_comb begin
    ld_d  = ld_q;
    io_d  = io_q;
    err_d = err_q;
    if (done && !gnt_q) begin
      ld_d.vld = 1'b0;
    end
    if (done && gnt_q) begin
      io_d.vld = 1'b0;
    end
    if (ld_wr) begin
      if (ld_q.vld) begin
        err_d = 1'b1;
      end else begin
        ld_d = {1'b1, ld_addr, ld_data};
      end
    end
    if (io_wr) begin
      if (io_q.vld) begin
        err_d = 1'b1;
      end else begin
        io_d = {1'b1, io_addr, io_data};
      end
    end
    if (tmo) begin
      err_d = 1'b1;
    end
  end

  // Execute waits for an idle port, empty entries and loader done.
  assign fire = pend_q && (state_q == S_IDLE) &&
                !any_vld && !ld_active;

  // Deferred execute request and its entry address.
  always_comb begin
    pend_d  = exec_req | (pend_q & ~fire);
    xaddr_d = exec_req ? exec_addr : xaddr_q;
    xgo_d   = fire;
    pc_d    = fire ? xaddr_q : pc_q;
  end

  // Download window stays open until every held entry has drained.
  always_comb begin
    dn_go_d = ld_active | io_active | any_vld |
              (state_q != S_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      ld_q      <= '0;
      io_q      <= '0;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      dn_addr_q <= '0;
      dn_data_q <= '0;
      dn_go_q   <= 1'b0;
      pend_q    <= 1'b0;
      xaddr_q   <= '0;
      pc_q      <= '0;
      xgo_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ld_q      <= ld_d;
      io_q      <= io_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      dn_addr_q <= dn_addr_d;
      dn_data_q <= dn_data_d;
      dn_go_q   <= dn_go_d;
      pend_q    <= pend_d;
      xaddr_q   <= xaddr_d;
      pc_q      <= pc_d;
      xgo_q     <= xgo_d;
      err_q     <= err_d;
    end
  end

  // FSM outputs and port drives.
  always_comb begin
    dn_wr   = (state_q == S_ISSUE);
    dn_go   = dn_go_q;
    dn_addr = dn_addr_q;
    dn_data = dn_data_q;
    ld_wait = ld_q.vld;
    io_wait = io_q.vld;
    exec_go = xgo_q;
    exec_pc = pc_q;
    err     = err_q;
  end

endmodule

// File: tb/tb_dn_port_arbiter.sv
// tb_dn_port_arbiter: directed and random checks of dn_port_arbiter.
// Random writes are checked against per-source FIFO expectations.
module tb_dn_port_arbiter;

  logic        clk_sys   = 1'b0;
  logic        reset_n   = 1'b0;
  logic        ld_active = 1'b0;
  logic        ld_wr     = 1'b0;
  logic [15:0] ld_addr   = '0;
  logic [7:0]  ld_data   = '0;
  logic        ld_wait;
  logic        io_active = 1'b0;
  logic        io_wr     = 1'b0;
  logic [15:0] io_addr   = '0;
  logic [7:0]  io_data   = '0;
  logic        io_wait;
  logic        exec_req  = 1'b0;
  logic [15:0] exec_addr = '0;
  logic        dn_go;
  logic        dn_wr;
  logic [23:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_ack    = 1'b0;
  logic        exec_go;
  logic [15:0] exec_pc;
  logic        err;

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;

  bit ack_en  = 1'b1;
  bit man_ack = 1'b0;
  int ack_max = 1;
  int ack_cnt = 0;

  logic [31:0] wr_log[$];
  int          wr_cyc[$];
  logic [15:0] ex_log[$];
  int          ex_cyc  = 0;
  int          ack_cyc = 0;

  logic [31:0] exp_ld[$];
  logic [31:0] exp_io[$];

  dn_port_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .ld_active (ld_active),
    .ld_wr     (ld_wr),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .ld_wait   (ld_wait),
    .io_active (io_active),
    .io_wr     (io_wr),
    .io_addr   (io_addr),
    .io_data   (io_data),
    .io_wait   (io_wait),
    .exec_req  (exec_req),
    .exec_addr (exec_addr),
    .dn_go     (dn_go),
    .dn_wr     (dn_wr),
    .dn_addr   (dn_addr),
    .dn_data   (dn_data),
    .dn_ack    (dn_ack),
    .exec_go   (exec_go),
    .exec_pc   (exec_pc),
    .err       (err)
  );

  always #5 clk_sys = ~clk_sys;

  // Core model: acks after a delay and logs port activity.
  always begin
    @(posedge clk_sys);
    #2;
    cyc++;
    dn_ack = man_ack;
    if (ack_cnt > 0) begin
      ack_cnt--;
      if (ack_cnt == 0) dn_ack = 1'b1;
    end
    if (dn_wr && ack_en) begin
      ack_cnt = (ack_max > 1) ? int'($urandom_range(ack_max, 1)) : 1;
    end
    if (dn_ack) ack_cyc = cyc;
    if (dn_wr) begin
      wr_log.push_back({dn_addr, dn_data});
      wr_cyc.push_back(cyc);
    end
    if (exec_go) begin
      ex_log.push_back(exec_pc);
      ex_cyc = cyc;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((ld_wait || io_wait) && n < 200) begin
      step();
      n++;
    end
    chk(tag, {31'd0, ld_wait | io_wait}, 32'd0);
    repeat (3) step();
  endtask

  task automatic ld_write(input logic [15:0] a, input logic [7:0] d);
    ld_addr = a;
    ld_data = d;
    ld_wr   = 1'b1;
    step();
    ld_wr   = 1'b0;
  endtask

  task automatic both_write(input logic [15:0] la, input logic [7:0] ldv,
                            input logic [15:0] ia, input logic [7:0] idv);
    ld_addr = la;
    ld_data = ldv;
    io_addr = ia;
    io_data = idv;
    ld_wr   = 1'b1;
    io_wr   = 1'b1;
    step();
    ld_wr   = 1'b0;
    io_wr   = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_go"},   {31'd0, dn_go}, 32'd0);
    chk({tag, "_wr"},   {31'd0, dn_wr}, 32'd0);
    chk({tag, "_addr"}, {8'd0, dn_addr}, 32'd0);
    chk({tag, "_data"}, {24'd0, dn_data}, 32'd0);
    chk({tag, "_xgo"},  {31'd0, exec_go}, 32'd0);
    chk({tag, "_pc"},   {16'd0, exec_pc}, 32'd0);
    chk({tag, "_err"},  {31'd0, err}, 32'd0);
    chk({tag, "_ldw"},  {31'd0, ld_wait}, 32'd0);
    chk({tag, "_iow"},  {31'd0, io_wait}, 32'd0);
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] e;
    int n;

    // Reset values
    step();
    step();
    chk_zero("rst");
    reset_n = 1'b1;
    step();

    // Tie after reset: loader first, then alternation
    wr_log.delete();
    wr_cyc.delete();
    chk("go_pre", {31'd0, dn_go}, 32'd0);
    ld_active = 1'b1;
    io_active = 1'b1;
    both_write(16'h5000, 8'h11, 16'h0000, 8'h22);
    chk("go_lag", {31'd0, dn_go}, 32'd1);
    chk("tie_ldw", {31'd0, ld_wait}, 32'd1);
    chk("tie_iow", {31'd0, io_wait}, 32'd1);
    drain("tie1_drain");
    ld_write(16'h5001, 8'h33);
    drain("single_drain");
    both_write(16'h5002, 8'h55, 16'h0001, 8'h44);
    drain("tie2_drain");
    chk("tie_cnt", wr_log.size(), 32'd5);
    if (wr_log.size() == 5) begin
      chk("tie_w0", wr_log[0], 32'h00500011);
      chk("tie_w1", wr_log[1], 32'h01000022);
      chk("tie_w2", wr_log[2], 32'h00500133);
      chk("tie_w3", wr_log[3], 32'h01000144);
      chk("tie_w4", wr_log[4], 32'h00500255);
      chk("tie_gap", wr_cyc[1] - wr_cyc[0], 32'd3);
    end
    io_active = 1'b0;

    // Single loader write with 1-cycle ack
    ld_write(16'h4A00, 8'h3E);
    chk("t1_wait1", {31'd0, ld_wait}, 32'd1);
    chk("t1_wr1", {31'd0, dn_wr}, 32'd0);
    step();
    chk("t1_wr", {31'd0, dn_wr}, 32'd1);
    chk("t1_addr", {8'd0, dn_addr}, 32'h004A00);
    chk("t1_data", {24'd0, dn_data}, 32'h3E);
    chk("t1_wait2", {31'd0, ld_wait}, 32'd1);
    step();
    chk("t1_wait3", {31'd0, ld_wait}, 32'd1);
    chk("t1_wr_once", {31'd0, dn_wr}, 32'd0);
    step();
    chk("t1_wait4", {31'd0, ld_wait}, 32'd0);
    chk("t1_err", {31'd0, err}, 32'd0);
    repeat (2) step();

`ifdef DN_ARB_TIMEOUT_EN
    // Missing ack: entry dropped after 8 cycles, next one issued
    ack_en = 1'b0;
    wr_log.delete();
    wr_cyc.delete();
    both_write(16'h6000, 8'h01, 16'h0200, 8'h02);
    n = 0;
    while (wr_log.size() < 1 && n < 50) begin
      step();
      n++;
    end
    ack_en = 1'b1;
    drain("tmo_drain");
    chk("tmo_cnt", wr_log.size(), 32'd2);
    if (wr_log.size() == 2) begin
      chk("tmo_gap", wr_cyc[1] - wr_cyc[0], 32'd10);
    end
    chk("tmo_err", {31'd0, err}, 32'd1);
    do_reset();
`else
    // Without ack the port waits; acks in IDLE/ISSUE are ignored
    ack_en = 1'b0;
    wr_log.delete();
    man_ack = 1'b1;
    step();
    man_ack = 1'b0;
    ld_write(16'h6000, 8'h77);
    step();
    chk("hold_wr", {31'd0, dn_wr}, 32'd1);
    man_ack = 1'b1;
    step();
    man_ack = 1'b0;
    repeat (30) step();
    chk("hold_wait", {31'd0, ld_wait}, 32'd1);
    chk("hold_cnt", wr_log.size(), 32'd1);
    man_ack = 1'b1;
    step();
    man_ack = 1'b0;
    step();
    chk("hold_rel", {31'd0, ld_wait}, 32'd0);
    chk("hold_err", {31'd0, err}, 32'd0);
    ack_en = 1'b1;
    repeat (2) step();
`endif

    // Overflow on the cassette holding register
    wr_log.delete();
    io_active = 1'b1;
    io_addr = 16'h0100;
    io_data = 8'hAA;
    io_wr = 1'b1;
    step();
    io_addr = 16'h0101;
    io_data = 8'hBB;
    step();
    io_wr = 1'b0;
    chk("ovf_err", {31'd0, err}, 32'd1);
    drain("ovf_drain");
    chk("ovf_cnt", wr_log.size(), 32'd1);
    if (wr_log.size() == 1) chk("ovf_w0", wr_log[0], 32'h010100AA);
    chk("ovf_sticky", {31'd0, err}, 32'd1);
    io_active = 1'b0;
    do_reset();
    chk("ovf_clr", {31'd0, err}, 32'd0);

    // Execute deferred until writes drain and loader is done
    wr_log.delete();
    ex_log.delete();
    ld_active = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ld_write(16'h5100 + 16'(i), 8'(i + 1));
      if (i == 0) begin
        exec_addr = 16'h1111;
        exec_req = 1'b1;
      end else if (i == 2) begin
        exec_addr = 16'h5200;
        exec_req = 1'b1;
      end
      step();
      exec_req = 1'b0;
      n = 0;
      while (ld_wait && n < 50) begin
        step();
        n++;
      end
    end
    repeat (6) step();
    chk("ex_held", ex_log.size(), 32'd0);
    chk("ex_wrs", wr_log.size(), 32'd3);
    ld_active = 1'b0;
    repeat (6) step();
    chk("ex_cnt", ex_log.size(), 32'd1);
    if (ex_log.size() == 1) chk("ex_pc", {16'd0, ex_log[0]}, 32'h5200);
    chk("ex_after_ack", {31'd0, ex_cyc > ack_cyc}, 32'd1);
    chk("ex_pulse", {31'd0, exec_go}, 32'd0);
    chk("ex_pc_hold", {16'd0, exec_pc}, 32'h5200);
    chk("ex_go_off", {31'd0, dn_go}, 32'd0);

    // Execute requested together with a write: fires 2 after the ack
    ex_log.delete();
    ld_addr = 16'h5300;
    ld_data = 8'h99;
    ld_wr = 1'b1;
    exec_addr = 16'h5300;
    exec_req = 1'b1;
    step();
    ld_wr = 1'b0;
    exec_req = 1'b0;
    repeat (8) step();
    chk("ex2_cnt", ex_log.size(), 32'd1);
    chk("ex2_gap", ex_cyc - ack_cyc, 32'd2);

    // Random traffic from both sources, honouring backpressure
    wr_log.delete();
    exp_ld.delete();
    exp_io.delete();
    ack_max = 3;
    ld_active = 1'b1;
    io_active = 1'b1;
    for (int i = 0; i < 400; i++) begin
      ld_wr = 1'b0;
      io_wr = 1'b0;
      if (!ld_wait && $urandom_range(1, 0) == 1) begin
        ld_addr = 16'($urandom);
        ld_data = 8'($urandom);
        ld_wr = 1'b1;
        exp_ld.push_back({8'h00, ld_addr, ld_data});
      end
      if (!io_wait && $urandom_range(1, 0) == 1) begin
        io_addr = 16'($urandom);
        io_data = 8'($urandom);
        io_wr = 1'b1;
        exp_io.push_back({8'h01, io_addr, io_data});
      end
      step();
    end
    ld_wr = 1'b0;
    io_wr = 1'b0;
    drain("rnd_drain");
    foreach (wr_log[i]) begin
      w = wr_log[i];
      if (w[31:24] == 8'h01 && exp_io.size() > 0) e = exp_io.pop_front();
      else if (w[31:24] == 8'h00 && exp_ld.size() > 0) e = exp_ld.pop_front();
      else e = 32'hxxxxxxxx;
      chk("rnd_wr", w, e);
    end
    chk("rnd_ld_left", exp_ld.size(), 32'd0);
    chk("rnd_io_left", exp_io.size(), 32'd0);
    chk("rnd_err", {31'd0, err}, 32'd0);
    ack_max = 1;

    // Reset mid-transfer discards entries and the pending execute
    ack_en = 1'b0;
    exec_addr = 16'h1234;
    exec_req = 1'b1;
    step();
    exec_req = 1'b0;
    both_write(16'h7000, 8'h5A, 16'h0300, 8'hA5);
    step();
    step();
    chk("mid_both", {30'd0, ld_wait, io_wait}, 32'd3);
    #2;
    reset_n = 1'b0;
    #1;
    chk_zero("mid_rst");
    step();
    ld_active = 1'b0;
    io_active = 1'b0;
    ack_en = 1'b1;
    reset_n = 1'b1;
    wr_log.delete();
    ex_log.delete();
    repeat (20) step();
    chk("mid_no_wr", wr_log.size(), 32'd0);
    chk("mid_no_ex", ex_log.size(), 32'd0);
    chk("mid_go", {31'd0, dn_go}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/dn_port_arbiter.md
# dn_port_arbiter

Sequences and shares the TRS-80 RAM download port (`dn_go`/`dn_wr`/`dn_addr`/`dn_data`) between two write sources: the CMD loader and the direct cassette ioctl stream. Each source gets a one-entry holding register with a wait/backpressure output, and the port is granted round-robin with a per-write acknowledge handshake. A pending CMD execute request is deferred until all accepted writes have drained, so the CPU never jumps into partially loaded memory. Sits in the top level between `cmd_loader`/`hps_io` and the `trs80` core, replacing the combinational download mux.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 1024: ack timeout in `clk_sys` cycles. Only used with `DN_ARB_TIMEOUT_EN`. Legal range 2..65535.

Ports:
- `clk_sys` in 1: system clock (42 MHz).
- `reset_n` in 1: reset. Asynchronous, active-low.
- `ld_active` in 1: loader download in progress.
- `ld_wr` in 1: loader write strobe, one cycle.
- `ld_addr` in 16: loader CPU address.
- `ld_data` in 8: loader write data.
- `ld_wait` out 1: loader holding register full.
- `io_active` in 1: cassette ioctl download in progress.
- `io_wr` in 1: cassette write strobe, one cycle.
- `io_addr` in 16: cassette byte offset.
- `io_data` in 8: cassette write data.
- `io_wait` out 1: cassette holding register full. Drives `ioctl_wait`.
- `exec_req` in 1: execute request pulse from the loader.
- `exec_addr` in 16: program entry address.
- `dn_go` out 1: download window to the core.
- `dn_wr` out 1: write strobe to the core, one cycle per write.
- `dn_addr` out 24: write address.
- `dn_data` out 8: write data.
- `dn_ack` in 1: core has committed the write, one-cycle pulse.
- `exec_go` out 1: execute pulse to the core, one cycle.
- `exec_pc` out 16: entry address. Valid while `exec_go` is high; holds its value afterwards.
- `err` out 1: sticky error flag, cleared only by reset.

## Operation
- Address mapping:
  - Loader writes go to `{8'h00, ld_addr}`.
  - Cassette writes go to `{8'h01, io_addr}`, i.e. 0x10000–0x1FFFF.
- Holding registers: a `*_wr` strobe with its holding register empty captures addr/data and sets `valid`. `*_wait` equals `valid`.
- Overflow: a `*_wr` strobe while `valid` is set is dropped. The held entry is unchanged and `err` is set.
- Arbiter FSM states: IDLE, ISSUE, WAIT_ACK.
  - IDLE → ISSUE when any `valid` is set. If only one is set, grant it. If both are set, grant the source not granted last (`last_grant`, reset = cassette, so the loader wins the first tie). `dn_addr`/`dn_data` are registered from the granted entry.
  - ISSUE → WAIT_ACK unconditionally. `dn_wr` is high for exactly this one cycle.
  - WAIT_ACK → IDLE on `dn_ack`. This clears the granted source's `valid` and updates `last_grant`.
- `dn_ack` is ignored in IDLE and ISSUE.
- Execute:
  - `exec_req` sets `exec_pend` and latches `exec_addr`. A second request while pending overwrites the address.
  - In IDLE with both `valid` clear and `ld_active` low, `exec_pend` produces a one-cycle `exec_go` and clears.
  - Writes always take precedence over execute.
- `dn_go` (registered) = `ld_active | io_active | ld_valid | io_valid | (state != IDLE)`. Entries still held when a download deasserts are drained before `dn_go` falls.
- Reset values: all outputs 0 (including `dn_addr`, `dn_data` and `exec_pc`), state IDLE, both `valid` clear, `exec_pend` clear.
- Asserting `reset_n` low mid-transfer discards held entries and any pending execute immediately.

## Timing
- `*_wr` sampled at cycle N:
  - `valid` and `*_wait` high at N+1.
  - Earliest `dn_wr` at N+2.
  - Earliest `dn_ack` at N+3.
  - `valid` and `*_wait` low at N+4.
- Minimum spacing between `dn_wr` pulses: 3 cycles (ack arriving the cycle after `dn_wr`).
- A `*_wr` strobe in the same cycle its `valid` clears is treated as overflow, since `valid` is still set in that cycle.
- `exec_go` asserts no earlier than the cycle after the final ack's IDLE entry.
- `dn_go` lags its inputs by one cycle.

## Configuration
- `DN_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter runs in WAIT_ACK.
  - After `TIMEOUT_CYCLES` cycles without `dn_ack`, the granted entry is dropped, `err` is set, `last_grant` is updated, and the FSM returns to IDLE.
- Not defined: WAIT_ACK waits indefinitely and `err` reflects overflow only.

## Test plan
- Single loader write 0x4A00 ← 0x3E, ack 1 cycle after `dn_wr` → one `dn_wr` with `dn_addr`=0x004A00, `dn_data`=0x3E; `ld_wait` high for 3 cycles; `err`=0.
- Both sources strobe the same cycle (loader 0x5000/0x11, cassette 0x0000/0x22) → loader issued first, then cassette at 0x010000; repeated ties alternate.
- `io_wr` again while `io_wait` is high → second byte absent from the `dn_*` outputs, first byte written, `err`=1.
- Loader writes three bytes, then `exec_req` with 0x5200 while `ld_active` is still high; `ld_active` falls after the last ack → single `exec_go` with `exec_pc`=0x5200, only after the third ack and `ld_active` low.
- With `DN_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, no ack → FSM back to IDLE 8 cycles after entering WAIT_ACK, `err`=1, next queued entry issued.
- `reset_n` pulsed low during WAIT_ACK with both entries valid → all outputs 0 immediately; no `dn_wr` or `exec_go` after release.
